// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and constants for the data-memory controller.
//   state_e   : controller FSM states (IDLE, REQ, WAIT, DONE)
//   size_e    : access size (byte, half, word)
//   BE_*      : unshifted byte-enable patterns per access size
//   lane_off  : byte lane of the access inside the 32-bit word
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Halves only honour addr[1] and words always sit in lane 0, so
    // misaligned addresses degrade to the containing aligned slot.
    function automatic logic [1:0] lane_off(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: return a;
            SZ_HALF: return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// load_ext -- combinational load alignment and extension.
//   rdata_i  : raw bus read word
//   size_i   : access size
//   off_i    : byte lane of the access
//   exsign_i : 1 = sign-extend, 0 = zero-extend
//   data_o   : right-aligned, extended load result
module load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  size_e       size_i,
    input  logic [1:0]  off_i,
    input  logic        exsign_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;

    always_comb begin
        sh = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SZ_BYTE: data_o = {{24{exsign_i & sh[7]}}, sh[7:0]};
            SZ_HALF: data_o = {{16{exsign_i & sh[15]}}, sh[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- pipeline data-memory controller bridging load/store requests
// onto a simple req/gnt/rvalid bus.
//   Pipeline side : mem_re, mem_we, isByte, isHalf, exsign, addr, wdata in;
//                   stall, load_data, load_valid, bus_err (, misalign) out.
//   Bus side      : bus_req, bus_we, bus_addr, bus_be, bus_wdata out;
//                   bus_gnt, bus_rvalid, bus_rdata in.
//   TIMEOUT       : cycles allowed in REQ+WAIT before the access is aborted.
// Optional feature: define DMEM_MISALIGN_EXC_EN to reject misaligned half/word
// requests with a misalign pulse instead of silently aligning them.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic        isByte,
    input  logic        isHalf,
    input  logic        exsign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
`ifdef DMEM_MISALIGN_EXC_EN
    output logic        misalign,
`endif
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ldata_q, ldata_d;
    logic        err_q, err_d;
    logic [29:0] waddr_q;
    size_e       size_q;
    logic [1:0]  off_q;
    logic        we_q, sx_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    size_e       req_sz;
    logic [1:0]  req_off;
    logic [3:0]  req_be;
    logic        req, accept, capture, timeout;
    logic [31:0] ext_data;

    // Request decode (IDLE side)
    assign req_sz  = isByte ? SZ_BYTE : (isHalf ? SZ_HALF : SZ_WORD);
    assign req_off = lane_off(req_sz, addr[1:0]);
    assign req     = mem_re | mem_we;

    always_comb begin
        case (req_sz)
            SZ_BYTE: req_be = BE_BYTE << req_off;
            SZ_HALF: req_be = BE_HALF << req_off;
            default: req_be = BE_WORD;
        endcase
    end

`ifdef DMEM_MISALIGN_EXC_EN
    logic mis;
    assign mis      = ((req_sz == SZ_HALF) & addr[0]) |
                      ((req_sz == SZ_WORD) & (addr[1:0] != 2'b00));
    assign accept   = req & ~mis;
    assign misalign = rst_n & (state_q == S_IDLE) & req & mis;
`else
    assign accept   = req;
`endif

    // Counter holds cycles already spent in REQ/WAIT; the abort fires in
    // the cycle that would make it reach TIMEOUT, so REQ+WAIT never
    // exceeds TIMEOUT cycles. Timeout is tested before gnt/rvalid.
    assign timeout = ((cnt_q + 8'd1) == TO);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ldata_d = ldata_q;
        err_d   = err_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (accept) begin
                    capture = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (timeout) begin
                    err_d   = 1'b1;
                    ldata_d = 32'd0;
                    state_d = S_DONE;
                end else if (bus_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (timeout) begin
                    err_d   = 1'b1;
                    ldata_d = 32'd0;
                    state_d = S_DONE;
                end else if (bus_rvalid) begin
                    ldata_d = ext_data;
                    state_d = S_DONE;
                end
            end
            default: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            ldata_q <= 32'd0;
            err_q   <= 1'b0;
            waddr_q <= 30'd0;
            size_q  <= SZ_WORD;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            sx_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ldata_q <= ldata_d;
            err_q   <= err_d;
            if (capture) begin
                waddr_q <= addr[31:2];
                size_q  <= req_sz;
                off_q   <= req_off;
                we_q    <= mem_we;   // store wins when both re and we are set
                sx_q    <= exsign;
                be_q    <= req_be;
                wdata_q <= wdata << {req_off, 3'b000};
            end
        end
    end

    load_ext u_load_ext (
        .rdata_i  (bus_rdata),
        .size_i   (size_q),
        .off_i    (off_q),
        .exsign_i (sx_q),
        .data_o   (ext_data)
    );

    assign stall      = rst_n & (((state_q == S_IDLE) & accept) |
                                 (state_q == S_REQ) | (state_q == S_WAIT));
    assign bus_req    = (state_q == S_REQ);
    assign bus_we     = (state_q == S_REQ) & we_q;
    assign bus_addr   = {waddr_q, 2'b00};
    assign bus_be     = be_q;
    assign bus_wdata  = wdata_q;
    assign load_data  = ldata_q;
    assign load_valid = (state_q == S_DONE) & ~we_q & ~err_q;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, mem_re, mem_we, isByte, isHalf, exsign;
    logic [31:0] addr, wdata, bus_rdata;
    logic        bus_gnt, bus_rvalid;
    logic        stall, load_valid, bus_err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    // Second instance with TIMEOUT=4, own request and grant lines.
    logic        t_re, t_gnt;
    logic        t_stall, t_load_valid, t_bus_err, t_bus_req, t_bus_we;
    logic [31:0] t_load_data, t_bus_addr, t_bus_wdata;
    logic [3:0]  t_bus_be;
`ifdef DMEM_MISALIGN_EXC_EN
    logic        misalign, t_misalign;
`endif

    dmem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mem_re(mem_re), .mem_we(mem_we),
        .isByte(isByte), .isHalf(isHalf), .exsign(exsign), .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .bus_err(bus_err),
`ifdef DMEM_MISALIGN_EXC_EN
        .misalign(misalign),
`endif
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    dmem_ctrl #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .mem_re(t_re), .mem_we(1'b0),
        .isByte(isByte), .isHalf(isHalf), .exsign(exsign), .addr(addr), .wdata(wdata),
        .stall(t_stall), .load_data(t_load_data), .load_valid(t_load_valid), .bus_err(t_bus_err),
`ifdef DMEM_MISALIGN_EXC_EN
        .misalign(t_misalign),
`endif
        .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_be(t_bus_be),
        .bus_wdata(t_bus_wdata), .bus_gnt(t_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: lane arithmetic straight from the access rules.
    function automatic int m_off(input size_e sz, input logic [31:0] a);
        if (sz == SZ_BYTE) return int'(a % 4);
        if (sz == SZ_HALF) return ((int'(a % 4)) / 2) * 2;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input size_e sz, input logic [31:0] a);
        int off = m_off(sz, a);
        if (sz == SZ_BYTE) return 4'(1 << off);
        if (sz == SZ_HALF) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input size_e sz, input logic [31:0] a, input logic [31:0] wd);
        return wd << (8 * m_off(sz, a));
    endfunction

    function automatic logic [31:0] m_ld(input size_e sz, input logic [31:0] a,
                                         input logic [31:0] rd, input logic sx);
        int nb;
        logic [31:0] one, mask, v;
        if (sz == SZ_WORD) return rd;
        nb   = (sz == SZ_BYTE) ? 8 : 16;
        one  = 32'd1;
        mask = (one << nb) - 32'd1;
        v    = (rd >> (8 * m_off(sz, a))) & mask;
        if (sx && v[nb-1]) v = v | ~mask;
        return v;
    endfunction

    // One full access from IDLE back to IDLE. gdel = idle cycles before gnt,
    // rdel = idle cycles before rvalid. Garbage rvalid/rdata is driven where
    // the controller must ignore it.
    task automatic run_access(input string tag, input logic re, input logic we, input size_e sz,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input logic sx, input int gdel, input int rdel,
                              input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld);
        mem_re = re; mem_we = we; isByte = (sz == SZ_BYTE); isHalf = (sz == SZ_HALF);
        addr = a; wdata = wd; exsign = sx;
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = ~rd;
        @(negedge clk);
        chk({tag, ".stall_idle"}, {stall, bus_req}, 2'b10);
        @(posedge clk); #1;
        mem_re = 1'b0; mem_we = 1'b0; addr = ~a; wdata = ~wd; exsign = ~sx;
        for (int i = 0; i < gdel; i++) begin
            @(negedge clk);
            chk({tag, ".req_hold"}, {bus_req, stall, load_valid}, 3'b110);
            @(posedge clk); #1;
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        chk({tag, ".req"}, {bus_req, bus_we, stall}, {1'b1, we, 1'b1});
        chk({tag, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
        chk({tag, ".bus_be"}, 32'(bus_be), 32'(ebe));
        chk({tag, ".bus_wdata"}, bus_wdata, ewd);
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        if (!we) begin
            bus_rvalid = 1'b0;
            for (int i = 0; i < rdel; i++) begin
                @(negedge clk);
                chk({tag, ".wait"}, {bus_req, stall, load_valid}, 3'b010);
                @(posedge clk); #1;
            end
            bus_rvalid = 1'b1; bus_rdata = rd;
            @(negedge clk);
            chk({tag, ".wait_rv"}, {bus_req, stall, load_valid}, 3'b010);
            @(posedge clk); #1;
            bus_rvalid = 1'b0; bus_rdata = ~rd;
        end
        // DONE: a fresh request here must be ignored
        mem_re = re; mem_we = we; addr = a; wdata = wd; exsign = sx;
        @(negedge clk);
        chk({tag, ".done"}, {stall, load_valid, bus_err, bus_req}, {1'b0, ~we, 1'b0, 1'b0});
        if (!we) chk({tag, ".load_data"}, load_data, eld);
        @(posedge clk); #1;
        mem_re = 1'b0; mem_we = 1'b0; bus_rvalid = 1'b1;
        @(negedge clk);
        chk({tag, ".idle"}, {stall, load_valid, bus_req, bus_err}, 4'b0000);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
    endtask

    typedef struct {
        logic        re, we;
        size_e       sz;
        logic [31:0] a, wd, rd;
        logic        sx;
        int          gdel, rdel;
        logic [3:0]  be;
        logic [31:0] bwd, ld;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, SZ_BYTE, 32'h1003, 32'h0,        32'h80FF_FF00, 1'b1, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80};
        tbl[1] = '{1'b0, 1'b1, SZ_HALF, 32'h2002, 32'h0000_BEEF, 32'h0,        1'b0, 0, 0, 4'b1100, 32'hBEEF_0000, 32'h0};
        tbl[2] = '{1'b1, 1'b0, SZ_HALF, 32'h0,    32'h0,        32'h0000_8001, 1'b0, 5, 0, 4'b0011, 32'h0,        32'h0000_8001};
        tbl[3] = '{1'b1, 1'b0, SZ_WORD, 32'h40,   32'h0,        32'hDEAD_BEEF, 1'b1, 1, 2, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        tbl[4] = '{1'b1, 1'b0, SZ_HALF, 32'h12,   32'h0,        32'h8123_4567, 1'b1, 0, 3, 4'b1100, 32'h0,        32'hFFFF_8123};
        tbl[5] = '{1'b1, 1'b0, SZ_BYTE, 32'h5,    32'h0,        32'h0000_F100, 1'b0, 0, 0, 4'b0010, 32'h0,        32'h0000_00F1};
        tbl[6] = '{1'b1, 1'b1, SZ_BYTE, 32'h7,    32'h0000_00A5, 32'h0,        1'b0, 0, 0, 4'b1000, 32'hA500_0000, 32'h0};
        tbl[7] = '{1'b0, 1'b1, SZ_WORD, 32'h100,  32'h1234_5678, 32'h0,        1'b0, 2, 0, 4'b1111, 32'h1234_5678, 32'h0};
        tbl[8] = '{1'b1, 1'b0, SZ_BYTE, 32'h2,    32'h0,        32'h007F_0000, 1'b1, 0, 0, 4'b0100, 32'h0,        32'h0000_007F};

        rst_n = 1'b0; mem_re = 1'b0; mem_we = 1'b0; isByte = 1'b0; isHalf = 1'b0; exsign = 1'b0;
        addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        t_re = 1'b0; t_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset.ctrl", {stall, load_valid, bus_err, bus_req, bus_we}, 5'b0);
        chk("reset.bus_addr", bus_addr, 32'h0);
        chk("reset.bus_be", 32'(bus_be), 32'h0);
        chk("reset.bus_wdata", bus_wdata, 32'h0);
        chk("reset.load_data", load_data, 32'h0);
        chk("reset.to_ctrl", {t_stall, t_load_valid, t_bus_err, t_bus_req}, 4'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table
        foreach (tbl[i])
            run_access($sformatf("tbl%0d", i), tbl[i].re, tbl[i].we, tbl[i].sz, tbl[i].a,
                       tbl[i].wd, tbl[i].rd, tbl[i].sx, tbl[i].gdel, tbl[i].rdel,
                       tbl[i].be, tbl[i].bwd, tbl[i].ld);

        // Randomized against the reference model
        for (int n = 0; n < 40; n++) begin
            int          op;
            size_e       sz;
            logic [31:0] a, wd, rd;
            logic        sx, re, we;
            op = int'($urandom_range(0, 2));
            sz = size_e'($urandom_range(0, 2));
            a  = $urandom; wd = $urandom; rd = $urandom;
            sx = 1'($urandom_range(0, 1));
`ifdef DMEM_MISALIGN_EXC_EN
            if (sz == SZ_HALF) a[0] = 1'b0;
            if (sz == SZ_WORD) a[1:0] = 2'b00;
`endif
            re = (op != 1);
            we = (op != 0);
            run_access($sformatf("rnd%0d", n), re, we, sz, a, wd, rd, sx,
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                       m_be(sz, a), m_wd(sz, a, wd), m_ld(sz, a, rd, sx));
        end

        // TIMEOUT=4 instance: good load (3 cycles in REQ+WAIT) first
        isByte = 1'b0; isHalf = 1'b0; exsign = 1'b0; addr = 32'h44;
        t_re = 1'b1;
        @(posedge clk); #1;
        t_re = 1'b0; t_gnt = 1'b1;
        @(negedge clk);
        chk("to_ok.req", {t_bus_req, t_stall}, 2'b11);
        @(posedge clk); #1;
        t_gnt = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("to_ok.done", {t_load_valid, t_bus_err}, 2'b10);
        chk("to_ok.load_data", t_load_data, 32'hCAFE_F00D);
        @(posedge clk); #1;

        // Pass 0: never granted. Pass 1: gnt in the 4th REQ cycle loses to timeout.
        for (int p = 0; p < 2; p++) begin
            t_re = 1'b1; t_gnt = 1'b0;
            @(negedge clk);
            chk($sformatf("to%0d.stall_idle", p), 32'(t_stall), 32'd1);
            @(posedge clk); #1;
            t_re = 1'b0; bus_rvalid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (p == 1 && i == 3) t_gnt = 1'b1;
                @(negedge clk);
                chk($sformatf("to%0d.req%0d", p, i), {t_bus_req, t_stall, t_bus_err}, 3'b110);
                @(posedge clk); #1;
            end
            t_gnt = 1'b0; bus_rvalid = 1'b0;
            @(negedge clk);
            chk($sformatf("to%0d.err", p), {t_bus_err, t_stall, t_load_valid, t_bus_req}, 4'b1000);
            chk($sformatf("to%0d.load_data", p), t_load_data, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("to%0d.after", p), {t_bus_err, t_stall, t_bus_req}, 3'b000);
            @(posedge clk); #1;
        end

        // Reset while waiting for read data, then a late rvalid
        isByte = 1'b0; isHalf = 1'b0; addr = 32'h80; mem_re = 1'b1;
        @(posedge clk); #1;
        mem_re = 1'b0; bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("rst_wait.in_wait", {bus_req, stall}, 2'b01);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_wait.ctrl", {stall, bus_req, load_valid, bus_err}, 4'b0);
        chk("rst_wait.load_data", load_data, 32'h0);
        rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("rst_wait.late_rv%0d", i), {stall, bus_req, load_valid}, 3'b000);
        end
        bus_rvalid = 1'b0;
        @(posedge clk); #1;

`ifdef DMEM_MISALIGN_EXC_EN
        mem_re = 1'b1; isByte = 1'b0; isHalf = 1'b0; addr = 32'h3001;
        @(negedge clk);
        chk("mis.pulse", {misalign, stall, bus_req}, 3'b100);
        @(posedge clk); #1;
        mem_re = 1'b0;
        @(negedge clk);
        chk("mis.after", {misalign, stall, bus_req}, 3'b000);
        @(posedge clk); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent in REQ+WAIT before the access is aborted (range 1..255).
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 mem_re  input  1  pipeline load request.
REQ-005 mem_we  input  1  pipeline store request.
REQ-006 isByte, isHalf  input  1 each  access size; neither asserted means word.
REQ-007 exsign  input  1  sign-extend the load (1) or zero-extend it (0).
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-aligned.
REQ-010 stall  output  1  freeze the pipeline.
REQ-011 load_data  output  32  extended load result; valid while load_valid is high.
REQ-012 load_valid  output  1  one-cycle pulse when a load completes.
REQ-013 bus_err  output  1  one-cycle pulse when an access times out.
REQ-014 misalign  output  1  one-cycle misaligned-access flag (present only with the macro, see Configuration).
REQ-015 bus_req, bus_we  output  1 each  bus request and bus write strobe.
REQ-016 bus_addr  output  32  word-aligned address; addr[1:0] SHALL be driven as 2'b00.
REQ-017 bus_be  output  4  byte enables.
REQ-018 bus_wdata  output  32  lane-shifted store data.
REQ-019 bus_gnt, bus_rvalid  input  1 each  request accepted; read data valid.
REQ-020 bus_rdata  input  32  raw read word.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DONE.
REQ-022 IDLE, when mem_re or mem_we is asserted: register the request and go to REQ.
  - stall = (IDLE & (mem_re|mem_we)) | REQ | WAIT, combinational.
REQ-023 When mem_re and mem_we are both asserted, the access SHALL be a store and the read SHALL be ignored.
REQ-024 REQ: bus_req = 1 with registered bus_addr, bus_we, bus_be and bus_wdata.
  - On bus_gnt, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-025 WAIT: on bus_rvalid, capture the extended data into load_data and go to DONE; bus_rvalid in any other state SHALL be ignored.
REQ-026 DONE: stall = 0, load_valid = 1 for loads only, then return to IDLE.
  - Request inputs SHALL be ignored during DONE.
REQ-027 Byte enables SHALL be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
  - bus_wdata = wdata << {addr[1:0],3'b0}.
REQ-028 Load extension:
  - shift bus_rdata right by {addr[1:0],3'b0};
  - take byte [7:0] or half [15:0];
  - fill the upper bits with the MSB if exsign, else with zeros;
  - a word load SHALL pass through unchanged.
REQ-029 An 8-bit counter SHALL clear on entry to REQ, increment each cycle in REQ or WAIT, and hold otherwise.
  - When the count equals TIMEOUT, go to DONE with bus_err = 1, load_data = 0 and load_valid = 0.
  - Timeout SHALL take priority over a same-cycle bus_gnt or bus_rvalid.
REQ-030 Minimum latency: load 3 cycles (request to load_valid, gnt and rvalid immediate); store 2 cycles.

Reset
REQ-031 With rst_n = 0 at a clock edge:
  - state SHALL go to IDLE and the counter to 0;
  - all outputs SHALL be 0, including stall, bus_req and load_data.
REQ-032 Reset mid-access SHALL drop bus_req on the next edge, and a late bus_rvalid SHALL be ignored.

Configuration
REQ-033 With DMEM_MISALIGN_EXC_EN defined, a misaligned request (half with addr[0] = 1, or word with addr[1:0] != 0) in IDLE SHALL:
  - pulse misalign for one cycle;
  - start no bus access;
  - keep stall = 0 and stay in IDLE.
REQ-034 Without DMEM_MISALIGN_EXC_EN, the misalign port SHALL be absent.
  - Misaligned half accesses SHALL use addr[1] only.
  - Misaligned word accesses SHALL ignore addr[1:0].

Structure
REQ-035 Package dmem_pkg SHALL hold the state enum, the access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the byte-enable constants.
REQ-036 Load extension SHALL be a sub-module, load_ext, that is purely combinational.

Verification
REQ-037 Byte load: addr=0x1003, exsign=1, rdata=0x80FF_FF00, immediate gnt and rvalid.
  - Expect be=0001 shifted to 1000, load_data=0xFFFF_FF80, load_valid pulsing 3 cycles after the request.
REQ-038 Half store: addr=0x2002, wdata=0x0000_BEEF.
  - Expect bus_be=1100, bus_wdata=0xBEEF_0000, bus_we=1, stall dropping 2 cycles after the request.
REQ-039 Delayed grant: gnt held low 5 cycles, unsigned half load of rdata=0x0000_8001 at addr 0.
  - Expect stall high throughout and load_data=0x0000_8001.
REQ-040 Timeout: TIMEOUT=4, no gnt.
  - Expect bus_err pulsing after 4 cycles in REQ, stall releasing, load_valid=0.
REQ-041 Reset during WAIT, then rvalid asserted.
  - Expect bus_req=0 after reset, no load_valid, and state IDLE.
REQ-042 Macro defined, word load at addr=0x3001.
  - Expect misalign=1 for one cycle, bus_req never asserted, stall=0.
